// File: rtl/mouse_master_sm.sv
// PS/2 mouse link sequencer: power-up command sequence (reset, self-test,
// device ID, enable streaming) followed by 3-byte movement packet assembly.
// All outputs are registered; a single shared counter provides the power-up
// delay and the per-byte reply timeout.
module mouse_master_sm #(
    parameter int POWERUP_DELAY = 500000,
    parameter int REPLY_TIMEOUT = 5000000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic       INIT_DONE
);

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(REPLY_TIMEOUT - 1);

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] REPLY_ACK    = 8'hFA;
    localparam logic [7:0] REPLY_PASSED = 8'hAA;
    localparam logic [7:0] REPLY_ID     = 8'h00;

    typedef enum logic [3:0] {
        POWERUP,
        TX_RESET,
        WAIT_TX_RESET,
        WAIT_ACK1,
        WAIT_SELFTEST,
        WAIT_ID,
        TX_ENABLE,
        WAIT_TX_ENABLE,
        WAIT_ACK2,
        PKT_B0,
        PKT_B1,
        PKT_B2,
        EMIT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_count_en;
    logic             w_timeout;
    logic             w_good;

    logic       r_send_byte;
    logic [7:0] r_byte_to_send;
    logic       r_read_enable;
    logic       r_init_done;
    logic       r_send_interrupt;
    logic [7:0] r_status_lat;
    logic [7:0] r_dx_lat;
    logic [7:0] r_mouse_status;
    logic [7:0] r_mouse_dx;
    logic [7:0] r_mouse_dy;

    // Receiver is enabled in every state that expects a byte, plus EMIT.
    function automatic logic rd_en(input state_t s);
        case (s)
            WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, WAIT_ACK2,
            PKT_B0, PKT_B1, PKT_B2, EMIT: rd_en = 1'b1;
            default:                      rd_en = 1'b0;
        endcase
    endfunction

    // Streaming is established once the final ACK has been seen.
    function automatic logic streaming(input state_t s);
        case (s)
            PKT_B0, PKT_B1, PKT_B2, EMIT: streaming = 1'b1;
            default:                      streaming = 1'b0;
        endcase
    endfunction

    assign w_good    = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign w_timeout = (r_cnt == TIMEOUT_LAST);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= POWERUP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a received byte always takes priority over the timeout.
    always_comb begin
        w_next_state = r_state;
        w_count_en   = 1'b0;
        case (r_state)
            POWERUP: begin
                w_count_en = 1'b1;
                if (r_cnt == POWERUP_LAST) w_next_state = TX_RESET;
            end
            TX_RESET:       w_next_state = WAIT_TX_RESET;
            WAIT_TX_RESET:  if (BYTE_SENT) w_next_state = WAIT_ACK1;
            WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, WAIT_ACK2: begin
                w_count_en = !BYTE_READY;
                if (BYTE_READY) begin
                    w_next_state = POWERUP;
                    if (r_state == WAIT_ACK1 && w_good && BYTE_READ == REPLY_ACK)
                        w_next_state = WAIT_SELFTEST;
                    if (r_state == WAIT_SELFTEST && w_good && BYTE_READ == REPLY_PASSED)
                        w_next_state = WAIT_ID;
                    if (r_state == WAIT_ID && w_good && BYTE_READ == REPLY_ID)
                        w_next_state = TX_ENABLE;
                    if (r_state == WAIT_ACK2 && w_good && BYTE_READ == REPLY_ACK)
                        w_next_state = PKT_B0;
                end else if (w_timeout) begin
                    w_next_state = POWERUP;
                end
            end
            TX_ENABLE:      w_next_state = WAIT_TX_ENABLE;
            WAIT_TX_ENABLE: if (BYTE_SENT) w_next_state = WAIT_ACK2;
            PKT_B0:         if (w_good && BYTE_READ[3]) w_next_state = PKT_B1;
            PKT_B1, PKT_B2: begin
                w_count_en = !BYTE_READY;
                if (BYTE_READY) begin
                    if (!w_good)                w_next_state = PKT_B0;
                    else if (r_state == PKT_B1) w_next_state = PKT_B2;
                    else                        w_next_state = EMIT;
                end else if (w_timeout) begin
                    w_next_state = PKT_B0;
                end
            end
            EMIT:           w_next_state = PKT_B0;
            default:        w_next_state = POWERUP;
        endcase
    end

    // Shared delay/timeout counter, cleared whenever the state changes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (w_count_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered outputs and packet byte latches.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_send_byte      <= 1'b0;
            r_byte_to_send   <= 8'h00;
            r_read_enable    <= 1'b0;
            r_init_done      <= 1'b0;
            r_send_interrupt <= 1'b0;
            r_status_lat     <= 8'h00;
            r_dx_lat         <= 8'h00;
            r_mouse_status   <= 8'h00;
            r_mouse_dx       <= 8'h00;
            r_mouse_dy       <= 8'h00;
        end else begin
            r_send_byte      <= (r_state == TX_RESET) || (r_state == TX_ENABLE);
            r_read_enable    <= rd_en(w_next_state);
            r_init_done      <= streaming(w_next_state);
            r_send_interrupt <= (w_next_state == EMIT);
            if (r_state == TX_RESET)  r_byte_to_send <= CMD_RESET;
            if (r_state == TX_ENABLE) r_byte_to_send <= CMD_ENABLE;
            if (r_state == PKT_B0 && w_next_state == PKT_B1) r_status_lat <= BYTE_READ;
            if (r_state == PKT_B1 && w_next_state == PKT_B2) r_dx_lat     <= BYTE_READ;
            if (r_state == PKT_B2 && w_next_state == EMIT) begin
                r_mouse_status <= r_status_lat;
                r_mouse_dx     <= r_dx_lat;
                r_mouse_dy     <= BYTE_READ;
            end
        end
    end

    assign SEND_BYTE      = r_send_byte;
    assign BYTE_TO_SEND   = r_byte_to_send;
    assign READ_ENABLE    = r_read_enable;
    assign INIT_DONE      = r_init_done;
    assign SEND_INTERRUPT = r_send_interrupt;
    assign MOUSE_STATUS   = r_mouse_status;
    assign MOUSE_DX       = r_mouse_dx;
    assign MOUSE_DY       = r_mouse_dy;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Scoreboard bench for mouse_master_sm: stimulus pushes expected command
// bytes and packets; a negedge monitor pops and compares them as they appear.
module tb_mouse_master_sm;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic       SEND_INTERRUPT;
    logic       INIT_DONE;

    mouse_master_sm #(
        .POWERUP_DELAY(16),
        .REPLY_TIMEOUT(64)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .SEND_BYTE(SEND_BYTE),
        .BYTE_TO_SEND(BYTE_TO_SEND),
        .BYTE_SENT(BYTE_SENT),
        .READ_ENABLE(READ_ENABLE),
        .BYTE_READ(BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY(BYTE_READY),
        .MOUSE_STATUS(MOUSE_STATUS),
        .MOUSE_DX(MOUSE_DX),
        .MOUSE_DY(MOUSE_DY),
        .SEND_INTERRUPT(SEND_INTERRUPT),
        .INIT_DONE(INIT_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_pkt;
        logic [23:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] model_out = 24'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every SEND_BYTE / SEND_INTERRUPT must match the next expectation.
    always @(negedge CLK) begin
        if (SEND_BYTE) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_send_byte: got %02h, nothing expected", BYTE_TO_SEND);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_pkt || mon_e.data[7:0] !== BYTE_TO_SEND) begin
                    errors++;
                    $display("FAIL send_byte: got %02h, required pkt=%0b %06h",
                             BYTE_TO_SEND, mon_e.is_pkt, mon_e.data);
                end else begin
                    $display("send_byte %02h", BYTE_TO_SEND);
                end
            end
        end
        if (SEND_INTERRUPT) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_interrupt: got %02h/%02h/%02h, nothing expected",
                         MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.is_pkt || mon_e.data !== {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}) begin
                    errors++;
                    $display("FAIL packet: got %02h/%02h/%02h, required pkt=%0b %06h",
                             MOUSE_STATUS, MOUSE_DX, MOUSE_DY, mon_e.is_pkt, mon_e.data);
                end else begin
                    $display("packet %02h/%02h/%02h", MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
                end
            end
        end
    end

    // Global bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic gap();
        repeat (2) tick();
    endtask

    task automatic send_reply(input logic [7:0] b, input logic [1:0] err);
        BYTE_READ       = b;
        BYTE_ERROR_CODE = err;
        BYTE_READY      = 1'b1;
        tick();
        BYTE_READY      = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
    endtask

    // Expect a command byte after 'delay' cycles, then act as the transmitter.
    task automatic do_tx(input logic [7:0] b, input int delay);
        int n;
        exp_q.push_back('{is_pkt: 1'b0, data: {16'h0, b}});
        n = 0;
        while (!SEND_BYTE && n < 200) begin
            tick();
            n++;
        end
        check("send_byte_delay", n, delay);
        check("read_enable_off_tx", READ_ENABLE, 0);
        repeat (3) tick();
        check("byte_to_send_hold", BYTE_TO_SEND, b);
        BYTE_SENT = 1'b1;
        tick();
        BYTE_SENT = 1'b0;
    endtask

    task automatic finish_init();
        send_reply(8'hAA, 2'b00);
        gap();
        send_reply(8'h00, 2'b00);
        do_tx(8'hF4, 1);
        gap();
        check("init_done_before_ack", INIT_DONE, 0);
        send_reply(8'hFA, 2'b00);
        check("init_done", INIT_DONE, 1);
        check("read_enable_streaming", READ_ENABLE, 1);
    endtask

    task automatic send_packet(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
        exp_q.push_back('{is_pkt: 1'b1, data: {s, x, y}});
        gap();
        check("hold_before_pkt", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, model_out);
        send_reply(s, 2'b00);
        gap();
        send_reply(x, 2'b00);
        gap();
        check("hold_before_last", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, model_out);
        send_reply(y, 2'b00);
        check("irq_latency", SEND_INTERRUPT, 1);
        check("pkt_outputs", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, {s, x, y});
        model_out = {s, x, y};
        tick();
        check("irq_one_cycle", SEND_INTERRUPT, 0);
    endtask

    initial begin
        RESET           = 1'b1;
        BYTE_SENT       = 1'b0;
        BYTE_READ       = 8'h00;
        BYTE_ERROR_CODE = 2'b00;
        BYTE_READY      = 1'b0;
        repeat (3) tick();
        check("reset_ctrl", {SEND_BYTE, READ_ENABLE, SEND_INTERRUPT, INIT_DONE, BYTE_TO_SEND}, 0);
        check("reset_mouse", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 0);
        RESET = 1'b0;

        // Nominal init
        do_tx(8'hFF, 17);
        gap();
        send_reply(8'hFA, 2'b00);
        gap();
        finish_init();

        // Packet, resync on a bad first byte, byte-1 timeout
        send_packet(8'h09, 8'h05, 8'hFB);
        gap();
        send_reply(8'h00, 2'b00);
        send_packet(8'h09, 8'h01, 8'h02);
        gap();
        send_reply(8'h09, 2'b00);
        repeat (70) tick();
        send_packet(8'h08, 8'h00, 8'h00);

        // Reset mid-packet
        gap();
        send_reply(8'h09, 2'b00);
        gap();
        send_reply(8'h01, 2'b00);
        gap();
        RESET = 1'b1;
        tick();
        check("midreset_ctrl", {SEND_BYTE, READ_ENABLE, SEND_INTERRUPT, INIT_DONE, BYTE_TO_SEND}, 0);
        check("midreset_mouse", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 0);
        model_out = 24'h0;
        RESET = 1'b0;
        do_tx(8'hFF, 17);

        // Bad self-test reply
        gap();
        send_reply(8'hFA, 2'b00);
        gap();
        send_reply(8'hFC, 2'b00);
        check("restart_read_enable", READ_ENABLE, 0);
        do_tx(8'hFF, 17);

        // Receiver error on the ACK
        gap();
        send_reply(8'hFA, 2'b01);
        check("err_restart_read_enable", READ_ENABLE, 0);
        do_tx(8'hFF, 17);

        // No ACK at all: 64 cycles of timeout plus the power-up delay
        do_tx(8'hFF, 81);
        check("timeout_init_done", INIT_DONE, 0);

        // ACK arriving in the last cycle before timeout is accepted
        repeat (63) tick();
        send_reply(8'hFA, 2'b00);
        check("late_ack_read_enable", READ_ENABLE, 1);
        gap();
        finish_init();
        send_packet(8'h18, 8'h7F, 8'h80);

        repeat (4) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
